// File: rtl/udp_tx_framer.sv
// Builds one Ethernet/IPv4/UDP frame per tx_start and streams it one byte per clock,
// fetching the payload as 32-bit words from an external RAM with one cycle of read latency.
// state    | meaning
// IDLE     | waiting for tx_start       PREAMBLE | 7x 55 + d5
// MAC      | dst then src MAC           TYPE     | ethertype 0800
// IP_HDR   | 20-byte IPv4 header        UDP_HDR  | 8-byte UDP header
// DATA     | payload bytes              PAD      | zero fill to 18 bytes
// FCS      | CRC-32, LSB first          IFG      | 12 idle cycles, tx_done on last
module udp_tx_framer #(
    parameter logic [15:0] BOARD_PORT = 16'd8080,
    parameter logic [15:0] PC_PORT    = 16'd8080,
    parameter logic [7:0]  IP_TTL     = 8'd64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tx_start,
    input  logic [15:0] tx_length,
    input  logic [47:0] board_mac,
    input  logic [47:0] pc_mac,
    input  logic [31:0] board_IP,
    input  logic [31:0] pc_IP,
    output logic        ram_rd_en,
    input  logic [31:0] ram_data,
    output logic [7:0]  dataout,
    output logic        e_txen,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, MAC, TYPE, IP_HDR, UDP_HDR, DATA, PAD, FCS, IFG
    } state_t;

    state_t      r_state;
    logic [10:0] r_left;
    logic [1:0]  r_bsel;
    logic [10:0] r_len;
    logic [8:0]  r_rd_left;
    logic [31:0] r_word;
    logic [31:0] r_crc;
    logic [15:0] r_csum;
    logic [47:0] r_pc_mac;
    logic [47:0] r_board_mac;
    logic [31:0] r_board_ip;
    logic [31:0] r_pc_ip;

    state_t      w_nstate;
    logic [10:0] w_nleft;
    logic [1:0]  w_nbsel;
    logic [7:0]  w_nbyte;
    logic        w_rd;
    logic        w_txen;
    logic [10:0] w_len_clamp;
    logic [10:0] w_len_p3;
    logic [15:0] w_tot_len;
    logic [15:0] w_udp_len;
    logic [19:0] w_sum;
    logic [16:0] w_fold;
    logic [15:0] w_csum;
    logic [95:0] w_mac;
    logic [159:0] w_ip_hdr;
    logic [63:0] w_udp_hdr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign w_len_clamp = (tx_length > 16'd1472) ? 11'd1472 : tx_length[10:0];
    assign w_len_p3    = w_len_clamp + 11'd3;
    assign w_tot_len   = 16'd28 + {5'd0, r_len};
    assign w_udp_len   = 16'd8 + {5'd0, r_len};

    // Header checksum with both end-around carries folded back in.
    assign w_sum  = 20'h04500 + {4'h0, w_tot_len} + 20'h04000 + {4'h0, IP_TTL, 8'h11}
                  + {4'h0, r_board_ip[31:16]} + {4'h0, r_board_ip[15:0]}
                  + {4'h0, r_pc_ip[31:16]} + {4'h0, r_pc_ip[15:0]};
    assign w_fold = {1'b0, w_sum[15:0]} + {13'h0, w_sum[19:16]};
    assign w_csum = ~(w_fold[15:0] + {15'h0, w_fold[16]});

    assign w_mac     = {r_pc_mac, r_board_mac};
    assign w_ip_hdr  = {16'h4500, w_tot_len, 16'h0000, 16'h4000, IP_TTL, 8'h11,
                        r_csum, r_board_ip, r_pc_ip};
    assign w_udp_hdr = {BOARD_PORT, PC_PORT, w_udp_len, 16'h0000};

    always_comb begin
        w_nstate = r_state;
        w_nleft  = r_left - 11'd1;
        w_nbsel  = r_bsel;
        if (r_state == IDLE) begin
            w_nleft = 11'd0;
            if (tx_start) begin
                w_nstate = PREAMBLE;
                w_nleft  = 11'd7;
            end
        end else if (r_left == 11'd0) begin
            case (r_state)
                PREAMBLE: begin w_nstate = MAC;     w_nleft = 11'd11; end
                MAC:      begin w_nstate = TYPE;    w_nleft = 11'd1;  end
                TYPE:     begin w_nstate = IP_HDR;  w_nleft = 11'd19; end
                IP_HDR:   begin w_nstate = UDP_HDR; w_nleft = 11'd7;  end
                UDP_HDR: begin
                    if (r_len != 11'd0) begin
                        w_nstate = DATA;
                        w_nleft  = r_len - 11'd1;
                        w_nbsel  = 2'd0;
                    end else begin
                        w_nstate = PAD;
                        w_nleft  = 11'd17;
                    end
                end
                DATA: begin
                    if (r_len < 11'd18) begin
                        w_nstate = PAD;
                        w_nleft  = 11'd17 - r_len;
                    end else begin
                        w_nstate = FCS;
                        w_nleft  = 11'd3;
                    end
                end
                PAD:      begin w_nstate = FCS; w_nleft = 11'd3;  end
                FCS:      begin w_nstate = IFG; w_nleft = 11'd11; end
                default:  begin w_nstate = IDLE; w_nleft = 11'd0; end
            endcase
        end else if (r_state == DATA) begin
            w_nbsel = r_bsel + 2'd1;
        end
    end

    // Each word is requested two bytes ahead so ram_data lands on its first byte slot.
    assign w_rd = (r_rd_left != 9'd0) &&
                  (((w_nstate == UDP_HDR) && (w_nleft == 11'd1)) ||
                   ((w_nstate == DATA) && (w_nbsel == 2'd2)));

    assign w_txen = (w_nstate != IDLE) && (w_nstate != IFG);

    always_comb begin
        w_nbyte = 8'h00;
        case (w_nstate)
            PREAMBLE: w_nbyte = (w_nleft == 11'd0) ? 8'hd5 : 8'h55;
            MAC:      w_nbyte = 8'(w_mac >> {w_nleft[3:0], 3'b000});
            TYPE:     w_nbyte = w_nleft[0] ? 8'h08 : 8'h00;
            IP_HDR:   w_nbyte = 8'(w_ip_hdr >> {w_nleft[4:0], 3'b000});
            UDP_HDR:  w_nbyte = 8'(w_udp_hdr >> {w_nleft[2:0], 3'b000});
            DATA:     w_nbyte = (w_nbsel == 2'd0) ? ram_data[31:24]
                                                  : 8'(r_word >> {~w_nbsel, 3'b000});
            FCS:      w_nbyte = 8'(~r_crc >> {~w_nleft[1:0], 3'b000});
            default:  w_nbyte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= IDLE;
            r_left      <= '0;
            r_bsel      <= '0;
            r_len       <= '0;
            r_rd_left   <= '0;
            r_word      <= '0;
            r_crc       <= '0;
            r_csum      <= '0;
            r_pc_mac    <= '0;
            r_board_mac <= '0;
            r_board_ip  <= '0;
            r_pc_ip     <= '0;
            dataout     <= 8'h00;
            e_txen      <= 1'b0;
            ram_rd_en   <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_left    <= w_nleft;
            r_bsel    <= w_nbsel;
            dataout   <= w_txen ? w_nbyte : 8'h00;
            e_txen    <= w_txen;
            ram_rd_en <= w_rd;
            tx_busy   <= (w_nstate != IDLE);
            tx_done   <= (w_nstate == IFG) && (w_nleft == 11'd0);
            if (w_rd)
                r_rd_left <= r_rd_left - 9'd1;
            if ((w_nstate == DATA) && (w_nbsel == 2'd0))
                r_word <= ram_data;
            if (r_state == PREAMBLE)
                r_csum <= w_csum;
            if ((r_state == IDLE) && tx_start) begin
                r_len       <= w_len_clamp;
                r_rd_left   <= w_len_p3[10:2];
                r_pc_mac    <= pc_mac;
                r_board_mac <= board_mac;
                r_board_ip  <= board_IP;
                r_pc_ip     <= pc_IP;
                r_crc       <= '1;
            end else if (w_nstate inside {MAC, TYPE, IP_HDR, UDP_HDR, DATA, PAD}) begin
                r_crc <= crc_byte(r_crc, w_nbyte);
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: a byte-level scoreboard fed by a frame model,
// plus frame-level timing, read-count, header-field and FCS-residue checks.
module tb_udp_tx_framer;

    logic        clk = 1'b0;
    logic        clr;
    logic        tx_start;
    logic [15:0] tx_length;
    logic [47:0] board_mac, pc_mac;
    logic [31:0] board_IP, pc_IP;
    logic        ram_rd_en;
    logic [31:0] ram_data;
    logic [7:0]  dataout;
    logic        e_txen, tx_busy, tx_done;

    udp_tx_framer dut (
        .clk(clk), .clr(clr), .tx_start(tx_start), .tx_length(tx_length),
        .board_mac(board_mac), .pc_mac(pc_mac), .board_IP(board_IP), .pc_IP(pc_IP),
        .ram_rd_en(ram_rd_en), .ram_data(ram_data), .dataout(dataout),
        .e_txen(e_txen), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [31:0] mem [0:511];
    int cyc = 0, txen_cnt = 0, rd_cnt = 0, rd_base = 0, done_cnt = 0;
    int rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
    bit mon_chk = 1'b0;
    bit prev_txen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] ob_at(input int idx);
        if (idx < obs_q.size()) return obs_q[idx];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
            else                      r = r >> 1;
        end
        return r;
    endfunction

    // RAM: word appears on ram_data for exactly the cycle after ram_rd_en
    always @(posedge clk) begin
        if (ram_rd_en === 1'b1) begin
            ram_data <= mem[9'(rd_cnt - rd_base)];
            rd_cnt   <= rd_cnt + 1;
        end else begin
            ram_data <= 32'h0BAD_F00D;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (e_txen === 1'b1) begin
            txen_cnt++;
            if (!prev_txen) rise_cyc = cyc;
            if (mon_chk) begin
                obs_q.push_back(dataout);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                chk("byte", {24'h0, dataout}, {24'h0, e});
            end
        end else if (prev_txen) begin
            fall_cyc = cyc;
        end
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_txen = (e_txen === 1'b1);
        cyc++;
    end

    task automatic push_frame(input int n);
        logic [7:0]  fb[$];
        logic [15:0] h[10];
        logic [31:0] sum, crc, w;
        for (int i = 5; i >= 0; i--) fb.push_back(pc_mac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(board_mac[i*8 +: 8]);
        fb.push_back(8'h08); fb.push_back(8'h00);
        h[0] = 16'h4500; h[1] = 16'(28 + n); h[2] = 16'h0000; h[3] = 16'h4000;
        h[4] = 16'h4011; h[5] = 16'h0000;
        h[6] = board_IP[31:16]; h[7] = board_IP[15:0];
        h[8] = pc_IP[31:16];    h[9] = pc_IP[15:0];
        sum = 32'h0;
        for (int i = 0; i < 10; i++) sum = sum + {16'h0, h[i]};
        while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        h[5] = ~sum[15:0];
        for (int i = 0; i < 10; i++) begin fb.push_back(h[i][15:8]); fb.push_back(h[i][7:0]); end
        fb.push_back(8'h1f); fb.push_back(8'h90); fb.push_back(8'h1f); fb.push_back(8'h90);
        w = 32'(8 + n);
        fb.push_back(w[15:8]); fb.push_back(w[7:0]); fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            w = mem[i / 4];
            fb.push_back(w[8*(3 - i % 4) +: 8]);
        end
        for (int i = n; i < 18; i++) fb.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (fb[i]) crc = crc_upd(crc, fb[i]);
        crc = ~crc;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hd5);
        foreach (fb[i]) exp_q.push_back(fb[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic run_frame(input int len, input int inject_at, input int exp_reads,
                             input int exp_burst, output int ob);
        int rd0, done0, tx0;
        bit got;
        logic [31:0] crc;
        @(negedge clk); #2;
        tx_length = 16'(len);
        push_frame((len > 1472) ? 1472 : len);
        ob = obs_q.size();
        rd_base = rd_cnt; rd0 = rd_cnt; done0 = done_cnt; tx0 = txen_cnt;
        tx_start = 1'b1;
        @(negedge clk); #2;
        tx_start = 1'b0;
        chk("busy_set", {31'h0, tx_busy}, 32'd1);
        chk("txen_first", {31'h0, e_txen}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #2;
            tx_start = (i == inject_at);
            if (done_cnt != done0) got = 1'b1;
        end
        tx_start = 1'b0;
        chk("done_seen", {31'h0, got}, 32'd1);
        chk("burst_len", txen_cnt - tx0, exp_burst);
        chk("contiguous", fall_cyc - rise_cyc, exp_burst);
        chk("ifg_done", done_cyc - fall_cyc, 32'd11);
        chk("reads", rd_cnt - rd0, exp_reads);
        chk("sb_empty", exp_q.size(), 32'd0);
        crc = 32'hFFFF_FFFF;
        for (int i = ob + 8; i < obs_q.size(); i++) crc = crc_upd(crc, obs_q[i]);
        chk("fcs_residue", crc, 32'hDEBB20E3);
        @(negedge clk); #2;
        chk("busy_clr", {31'h0, tx_busy}, 32'd0);
        chk("done_pulse", {31'h0, tx_done}, 32'd0);
        chk("done_once", done_cnt - done0, 32'd1);
        exp_q.delete();
    endtask

    initial begin
        int ob, done0, tx0;
        clr = 1'b0; tx_start = 1'b0; tx_length = 16'd0;
        board_mac = 48'h000a_3501_fec0; pc_mac = 48'h0011_2233_4455;
        board_IP  = 32'hc0a8_0002;       pc_IP  = 32'hc0a8_0003;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_txen", {31'h0, e_txen}, 32'd0);
        chk("rst_data", {24'h0, dataout}, 32'd0);
        chk("rst_rd", {31'h0, ram_rd_en}, 32'd0);
        chk("rst_busy", {31'h0, tx_busy}, 32'd0);
        chk("rst_done", {31'h0, tx_done}, 32'd0);
        clr = 1'b1;
        mon_chk = 1'b1;
        repeat (3) @(negedge clk);

        mem[0] = 32'hDEADBEEF;
        run_frame(4, -1, 1, 72, ob);
        chk("n4_ip_len", {16'h0, ob_at(ob + 24), ob_at(ob + 25)}, 32'd32);
        chk("n4_udp_len", {16'h0, ob_at(ob + 46), ob_at(ob + 47)}, 32'd12);
        chk("n4_payload", {ob_at(ob + 50), ob_at(ob + 51), ob_at(ob + 52), ob_at(ob + 53)},
            32'hDEADBEEF);

        run_frame(0, -1, 0, 72, ob);
        chk("n0_ip_len", {16'h0, ob_at(ob + 24), ob_at(ob + 25)}, 32'd28);

        for (int i = 0; i < 512; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F1E;
        run_frame(1473, -1, 368, 1526, ob);
        chk("clamp_ip_len", {16'h0, ob_at(ob + 24), ob_at(ob + 25)}, 32'd1500);

        run_frame(23, 55, 6, 77, ob);
        chk("n23_ip_csum", {16'h0, ob_at(ob + 32), ob_at(ob + 33)}, 32'h0000B964);

        @(negedge clk); #2;
        mon_chk = 1'b0;
        tx_length = 16'd8;
        tx_start = 1'b1;
        @(negedge clk); #2;
        tx_start = 1'b0;
        repeat (12) begin @(negedge clk); #2; end
        chk("pre_abort_txen", {31'h0, e_txen}, 32'd1);
        clr = 1'b0;
        #1;
        chk("abort_txen", {31'h0, e_txen}, 32'd0);
        chk("abort_data", {24'h0, dataout}, 32'd0);
        chk("abort_busy", {31'h0, tx_busy}, 32'd0);
        done0 = done_cnt;
        repeat (2) @(negedge clk);
        tx0 = txen_cnt;
        #2;
        clr = 1'b1;
        repeat (30) begin @(negedge clk); #2; end
        chk("abort_no_done", done_cnt - done0, 32'd0);
        chk("abort_quiet", txen_cnt - tx0, 32'd0);
        mon_chk = 1'b1;

        run_frame(18, -1, 5, 72, ob);

        board_mac = 48'h0200_0000_0001; pc_mac = 48'hffff_ffff_ffff;
        board_IP  = 32'h0a00_0001;       pc_IP  = 32'h0a00_00fe;
        run_frame(17, -1, 5, 72, ob);
        chk("n17_udp_len", {16'h0, ob_at(ob + 46), ob_at(ob + 47)}, 32'd25);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 The block SHALL have these parameters: BOARD_PORT, 16'd8080, UDP source port; PC_PORT, 16'd8080, UDP destination port; IP_TTL, 8'd64, IPv4 time-to-live.
REQ-002 The block SHALL have these ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 The block SHALL have: clr  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have: tx_start  in  1  one-cycle request to send one frame.
REQ-005 The block SHALL have: tx_length  in  16  UDP payload byte count N, sampled with tx_start.
REQ-006 The block SHALL have: board_mac, pc_mac  in  48 each  source and destination MAC; board_IP, pc_IP  in  32 each  source and destination IPv4; all sampled with tx_start.
REQ-007 The block SHALL have: ram_rd_en  out  1  payload word read strobe; ram_data  in  32  word valid exactly one cycle after ram_rd_en.
REQ-008 The block SHALL have: dataout  out  8  MII-side byte; e_txen  out  1  byte valid; tx_busy  out  1  frame in progress; tx_done  out  1  one-cycle pulse at end of frame.

Function
REQ-009 The block SHALL implement states IDLE, PREAMBLE, MAC, TYPE, IP_HDR, UDP_HDR, DATA, PAD, FCS, IFG.
REQ-010 In IDLE, tx_start=1 at edge k SHALL latch all inputs, set tx_busy, and drive e_txen=1 with dataout=8'h55 from edge k+1.
REQ-011 tx_start outside IDLE SHALL be ignored; no queueing.
REQ-012 tx_length > 1472 SHALL be clamped to 1472 at latch time.
REQ-013 PREAMBLE SHALL emit seven 8'h55 then one 8'hd5 (8 bytes).
REQ-014 MAC SHALL emit pc_mac then board_mac, MSB byte first (12 bytes); TYPE SHALL emit 8'h08, 8'h00.
REQ-015 IP_HDR SHALL emit 20 bytes MSB first: 45 00, total length 28+N, ident 0000, flags/frag 4000, IP_TTL, 8'h11, header checksum, board_IP, pc_IP.
REQ-016 Header checksum SHALL be the 16-bit one's-complement of the one's-complement sum of the nine other header halfwords, with end-around carries folded, computed during PREAMBLE/MAC and stable before the first IP_HDR byte.
REQ-017 UDP_HDR SHALL emit BOARD_PORT, PC_PORT, length 8+N, checksum 16'h0000.
REQ-018 DATA SHALL emit N bytes; each word SHALL be sent bits [31:24] first; ceil(N/4) reads SHALL be issued, each early enough that no byte cycle stalls; unused bytes of a final partial word SHALL be discarded.
REQ-019 N=0 SHALL skip DATA and issue no ram_rd_en.
REQ-020 If N<18, PAD SHALL emit 18-N bytes of 8'h00; otherwise PAD SHALL be skipped.
REQ-021 FCS SHALL emit IEEE 802.3 CRC-32 (reflected, init FFFFFFFF, final complement) over destination MAC through last PAD byte, least-significant byte first, 4 bytes.
REQ-022 e_txen SHALL be continuous from first preamble byte through last FCS byte, then 0; frame length in cycles SHALL equal 8+14+28+max(N,18)+4.
REQ-023 IFG SHALL hold e_txen=0 and dataout=8'h00 for 12 cycles; tx_done SHALL pulse in the last IFG cycle; tx_busy SHALL clear on entry to IDLE.

Reset
REQ-024 clr=0 SHALL immediately force IDLE, e_txen=0, dataout=8'h00, ram_rd_en=0, tx_busy=0, tx_done=0, counters and CRC state cleared.
REQ-025 clr asserted mid-frame SHALL abort the frame with no FCS and no tx_done; after release the block SHALL accept a new tx_start.

Verification
REQ-026 N=4, ram_data=32'hDEADBEEF -> 72-cycle e_txen burst, one ram_rd_en, payload DE AD BE EF then 14 zero pad bytes, valid FCS, IP total length 16'd32, UDP length 16'd12.
REQ-027 N=0 -> no ram_rd_en, 18 pad bytes, 72-cycle burst, tx_done 12 cycles after e_txen falls.
REQ-028 N=1473 -> clamped to 1472, 368 reads, total length 16'd1500, 1526-cycle burst, back-to-back bytes with no gaps.
REQ-029 N=23 -> 6 reads, last word bytes [7:0] discarded, no pad; IP checksum matches reference model for board_IP=192.168.0.2, pc_IP=192.168.0.3.
REQ-030 tx_start during DATA -> ignored; clr pulse during MAC -> e_txen=0 same cycle as clr falls, no tx_done, next tx_start yields a complete correct frame.
REQ-031 Loopback dataout/e_txen into the existing UDP receiver with its expected board MAC -> receiver recovers identical payload words and lengths.
